// File: rtl/ula_pkg.sv
// ula_pkg -- shared encodings for the ALU control sequencer.
//   ULAop classes from the main decoder, R-type function fields, ALU control
//   codes, the multi-cycle predicate and the sequencer FSM state enum.
package ula_pkg;

  // Main-decoder ALU op classes
  localparam logic [3:0] ULAOP_ADD   = 4'b0000;
  localparam logic [3:0] ULAOP_SUB   = 4'b0001;
  localparam logic [3:0] ULAOP_RTYPE = 4'b0010;
  localparam logic [3:0] ULAOP_AND   = 4'b0011;
  localparam logic [3:0] ULAOP_OR    = 4'b0100;
  localparam logic [3:0] ULAOP_LUI   = 4'b0101;
  localparam logic [3:0] ULAOP_SLT   = 4'b0110;
  localparam logic [3:0] ULAOP_SLTU  = 4'b0111;
  localparam logic [3:0] ULAOP_XOR   = 4'b1000;

  // R-type function fields
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101001;
  localparam logic [5:0] FN_XOR  = 6'b101011;
  localparam logic [5:0] FN_MUL  = 6'b100001;
  localparam logic [5:0] FN_DIV  = 6'b100011;
  localparam logic [5:0] FN_REM  = 6'b101000;

  // ALU control codes
  localparam logic [3:0] CTL_AND     = 4'b0000;
  localparam logic [3:0] CTL_OR      = 4'b0001;
  localparam logic [3:0] CTL_ADD     = 4'b0010;
  localparam logic [3:0] CTL_XOR     = 4'b0011;
  localparam logic [3:0] CTL_MUL     = 4'b0100;
  localparam logic [3:0] CTL_DIV     = 4'b0101;
  localparam logic [3:0] CTL_SUB     = 4'b0110;
  localparam logic [3:0] CTL_SLT     = 4'b0111;
  localparam logic [3:0] CTL_LUI     = 4'b1000;
  localparam logic [3:0] CTL_REM     = 4'b1001;
  localparam logic [3:0] CTL_NOR     = 4'b1100;
  localparam logic [3:0] CTL_SLTU    = 4'b1110;
  localparam logic [3:0] CTL_ILLEGAL = 4'b1111;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } seq_state_e;

  // Control codes that are executed by the iterative mul/div unit
  function automatic logic is_multi_code(input logic [3:0] code);
    return (code == CTL_MUL) || (code == CTL_DIV) || (code == CTL_REM);
  endfunction

endpackage

// File: rtl/ula_decode.sv
// ula_decode -- combinational ALU control decode.
//   ula_op_i    [3:0] main-decoder op class
//   func_code_i [5:0] R-type function field
//   code_o      [3:0] ALU control code (4'b1111 = illegal)
//   is_multi_o        code is executed by the iterative unit
// Build option: ULA_SEQCTL_MULDIV_EN enables the mul/div/rem function codes;
// without it they decode as illegal.
module ula_decode
  import ula_pkg::*;
(
  input  logic [3:0] ula_op_i,
  input  logic [5:0] func_code_i,
  output logic [3:0] code_o,
  output logic       is_multi_o
);

  logic [3:0] rtype_code;

  // R-type function field lookup
  always_comb begin
    rtype_code = CTL_ILLEGAL;
    case (func_code_i)
      FN_ADD:  rtype_code = CTL_ADD;
      FN_SUB:  rtype_code = CTL_SUB;
      FN_AND:  rtype_code = CTL_AND;
      FN_OR:   rtype_code = CTL_OR;
      FN_NOR:  rtype_code = CTL_NOR;
      FN_SLT:  rtype_code = CTL_SLT;
      FN_SLTU: rtype_code = CTL_SLTU;
      FN_XOR:  rtype_code = CTL_XOR;
`ifdef ULA_SEQCTL_MULDIV_EN
      FN_MUL:  rtype_code = CTL_MUL;
      FN_DIV:  rtype_code = CTL_DIV;
      FN_REM:  rtype_code = CTL_REM;
`endif
      default: rtype_code = CTL_ILLEGAL;
    endcase
  end

  // Op-class lookup; R-type defers to the function field
  always_comb begin
    code_o = CTL_ILLEGAL;
    case (ula_op_i)
      ULAOP_ADD:   code_o = CTL_ADD;
      ULAOP_SUB:   code_o = CTL_SUB;
      ULAOP_RTYPE: code_o = rtype_code;
      ULAOP_AND:   code_o = CTL_AND;
      ULAOP_OR:    code_o = CTL_OR;
      ULAOP_LUI:   code_o = CTL_LUI;
      ULAOP_SLT:   code_o = CTL_SLT;
      ULAOP_SLTU:  code_o = CTL_SLTU;
      ULAOP_XOR:   code_o = CTL_XOR;
      default:     code_o = CTL_ILLEGAL;
    endcase
  end

  assign is_multi_o = is_multi_code(code_o);

endmodule

// File: rtl/ula_seqctl.sv
// ula_seqctl -- ALU control sequencer for the EX stage.
//   Decodes the op presented with op_valid into a registered ALU control
//   code. Single-cycle ops pulse ctl_valid the next cycle. Multi-cycle ops
//   (mul/div/rem) stall the pipeline and drive the iterative unit through
//   DATA_W steps (md_start, md_step, md_last, step_cnt), then pulse md_done.
//   kill aborts anything pending or in flight.
// Ports: clk, rst_n (async, active-low), op_valid, ula_op[3:0],
//   func_code[5:0], kill -> ula_ctl[3:0], ctl_valid, illegal, stall,
//   md_start, md_step, md_last, step_cnt[CNT_W-1:0], md_done.
// Build option: ULA_SEQCTL_MULDIV_EN enables multi-cycle sequencing; without
// it mul/div/rem are illegal and the sequencer never leaves IDLE.
module ula_seqctl
  import ula_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [3:0]       ula_op,
  input  logic [5:0]       func_code,
  input  logic             kill,
  output logic [3:0]       ula_ctl,
  output logic             ctl_valid,
  output logic             illegal,
  output logic             stall,
  output logic             md_start,
  output logic             md_step,
  output logic             md_last,
  output logic [CNT_W-1:0] step_cnt,
  output logic             md_done
);

`ifdef ULA_SEQCTL_MULDIV_EN
  localparam logic MULDIV_EN = 1'b1;
`else
  localparam logic MULDIV_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  seq_state_e       state_q, state_d;
  logic [3:0]       ula_ctl_q, ula_ctl_d;
  logic             ctl_valid_q, ctl_valid_d;
  logic             illegal_q, illegal_d;
  logic             md_start_q, md_start_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;

  logic [3:0] dec_code;
  logic       dec_multi;
  logic       accept;
  logic       start_multi;
  logic       busy;
  logic       last_step;

  ula_decode u_decode (
    .ula_op_i    (ula_op),
    .func_code_i (func_code),
    .code_o      (dec_code),
    .is_multi_o  (dec_multi)
  );

  // Only IDLE accepts; kill always wins over op_valid
  assign accept      = op_valid && !kill && (state_q == ST_IDLE);
  assign start_multi = MULDIV_EN && accept && dec_multi;
  assign busy        = (state_q == ST_BUSY);
  assign last_step   = busy && (step_cnt_q == LAST_CNT);

  // Next-state and next-output computation
  always_comb begin
    state_d     = state_q;
    ula_ctl_d   = ula_ctl_q;
    ctl_valid_d = 1'b0;
    illegal_d   = 1'b0;
    md_start_d  = 1'b0;
    step_cnt_d  = step_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ula_ctl_d = dec_code;
          if (start_multi) begin
            state_d    = ST_BUSY;
            md_start_d = 1'b1;
            step_cnt_d = '0;
          end else begin
            ctl_valid_d = 1'b1;
            illegal_d   = (dec_code == CTL_ILLEGAL);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (kill) begin
          state_d    = ST_IDLE;
          step_cnt_d = '0;
        end else if (last_step) begin
          // counter holds at DATA_W-1 through DONE
          state_d = ST_DONE;
        end else begin
          step_cnt_d = step_cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (kill) begin
          step_cnt_d = '0;
        end else begin
          step_cnt_d = step_cnt_q;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        step_cnt_d = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ula_ctl_q   <= CTL_ILLEGAL;
      ctl_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      md_start_q  <= 1'b0;
      step_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ula_ctl_q   <= ula_ctl_d;
      ctl_valid_q <= ctl_valid_d;
      illegal_q   <= illegal_d;
      md_start_q  <= md_start_d;
      step_cnt_q  <= step_cnt_d;
    end
  end

  assign ula_ctl   = ula_ctl_q;
  assign ctl_valid = ctl_valid_q;
  assign illegal   = illegal_q;
  assign md_start  = md_start_q;
  assign step_cnt  = step_cnt_q;
  // stall rises in the accept cycle itself so upstream holds immediately
  assign stall     = busy || start_multi;
  assign md_step   = busy;
  assign md_last   = last_step;
  // a kill in DONE cancels the completion pulse
  assign md_done   = (state_q == ST_DONE) && !kill;

endmodule
